video_cga_crtc_regs: RTL and testbench
======================================

# video_cga_crtc_regs

6845-compatible CRTC register file and blink generator for the CGA video path, in the CPU clock domain. Decodes the CRTC index/data ports, holds R0–R17 with CGA 80x25 text defaults, and drives the start address, cursor address, cursor shape and blink phase consumed downstream by the CGA display pipeline (address generator and glyph stage). Also claims CPU reads of the data port.

## Interface
Parameters:
- `RESET_R9`, default 8'h07: reset value of R9, the max scan line register.
- `RESET_R10`, default 8'h06: reset value of R10, cursor start plus blink mode.
- `RESET_R11`, default 8'h07: reset value of R11, cursor end.

Ports (one clock; reset is asynchronous and active-low):
- `iClk` in 1: CPU-domain clock.
- `iRstN` in 1: asynchronous active-low reset.
- `iAddr` in 20: IO address; only bits [11:0] are decoded.
- `iWrData` in 8: IO write data.
- `iWrIo` in 1: IO write strobe, one cycle.
- `iRdIo` in 1: IO read strobe, one cycle.
- `iVgaVs` in 1: VGA vsync, positive pulse, asynchronous to `iClk`.
- `oRdData` out 8: read data.
- `oSel` out 1: read data valid.
- `oStartAddr` out 14: {R12[5:0], R13}.
- `oCursorAddr` out 14: {R14[5:0], R15}.
- `oCursorStart` out 5: R10[4:0].
- `oCursorEnd` out 5: R11[4:0].
- `oMaxScan` out 5: R9[4:0].
- `oCursorOn` out 1: cursor visible this field.
- `oCharBlink` out 1: blink-attribute phase.

## Operation
- Port decode uses `iAddr[11:0]`:
  - 3D0, 3D2, 3D4 and 3D6 are the index port.
  - 3D1, 3D3, 3D5 and 3D7 are the data port.
  - All other addresses are ignored.
- Index register:
  - 5 bits, written from `iWrData[4:0]`; reset value 0.
  - Index-port reads are not claimed: `oSel` stays 0.
- Data writes go to R[index] with unused bits masked to 0 on store.
  - Stored widths: R0–R3 8 bits; R4 7; R5 5; R6 7; R7 7; R8 2; R9 5; R10 7; R11 5; R12 6; R13 8; R14 6; R15 8.
  - R16, R17 and indices 18–31 ignore writes.
- Reset values:
  - R0 = 71, R1 = 50, R2 = 5A, R3 = 0A, R4 = 1F, R5 = 06, R6 = 19, R7 = 1C, R8 = 02 (all hex).
  - R9, R10 and R11 take their parameter values.
  - R12–R15 = 0.
- Data reads:
  - A read of any index is claimed: `oSel` = 1.
  - R14 and R15 return the stored value, zero-extended.
  - R12 and R13 return the stored value (CGA readback extension).
  - R16 and R17 (light pen) return 00.
  - All other indices return 00.
- Blink generator:
  - `iVgaVs` passes through a 2-flop synchronizer.
  - A rising edge of the synchronized signal increments a 5-bit field counter `fc`, which wraps 31→0.
  - `oCharBlink` = `fc[4]`.
- Cursor mode is R10[6:5]:
  - 00: steady on.
  - 01: off.
  - 10: blink, `oCursorOn` = `fc[3]`.
  - 11: blink, `oCursorOn` = `fc[4]`.
- Cursor start after end is not this block's concern: it passes values through unchanged.

## Timing
- Every output resets to its register-derived value:
  - `oRdData` = 00, `oSel` = 0.
  - `oStartAddr` = 0, `oCursorAddr` = 0.
  - `oCursorStart` = 06, `oCursorEnd` = 07, `oMaxScan` = 07.
  - `oCursorOn` = 1 (mode 00), `oCharBlink` = 0, `fc` = 0.
- Read latency is 1 cycle. `oRdData`/`oSel` are registered and are 00/0 in every cycle not following a claimed read.
- Writes take effect on the clock edge with the strobe. Register-derived outputs change on the following cycle.
- `oCursorOn` is registered; it updates 1 cycle after an `fc` or R10 change.
- Vsync edge to `fc` increment is 3 cycles (2 synchronizer stages plus the edge register).
- Simultaneous `iWrIo` and `iRdIo` on the data port:
  - The write commits.
  - The read returns the pre-write value.
- An index write and a data access in the same cycle cannot occur (different addresses), so no rule is needed.
- Reset mid-operation:
  - All state returns to reset values asynchronously.
  - A pending read is dropped: `oSel` = 0.
- Strobes are single-cycle. A strobe held for N cycles is N accesses.

## Structure
- Shared package `video_pkg` holds:
  - CRTC index constants (R_START_HI = 12, R_START_LO = 13, R_CURSOR_HI = 14, R_CURSOR_LO = 15, R_LPEN_HI = 16, R_LPEN_LO = 17).
  - Per-register reset values and width masks.
  - Cursor-mode encodings.
- Sub-module `video_blink_gen` contains the vsync synchronizer, edge detector and 5-bit field counter. It outputs `fc`.
- The register file and decode live in the top module.

## Test plan
- Reset release, then read R14/R15 via a write of 0E to 3D4 and a read of 3D5 → `oRdData` 00, `oSel` 1 one cycle later. All outputs at their reset values.
- Write 0C/3F then 0D/A5 to 3D4/3D5 → `oStartAddr` = 0x3FA5. Write FF to R12 → `oStartAddr[13:8]` = 3F (bits masked).
- Write 0F to 3D4, then 12 to 3D5 → `oCursorAddr[7:0]` = 12. Read back through 3D1 (mirror) → 12. Read R0 → 00, `oSel` 1. Read 3D4 → `oSel` 0.
- R10 = 0x46 (mode 10), pulse `iVgaVs` 8 times → `oCursorOn` rises after the 8th edge plus 4 cycles. Mode 01 → 0. Mode 00 → 1.
- 32 vsync pulses → `oCharBlink` toggles on the 16th and 32nd edges. `fc` wraps to 0.
- Simultaneous write 55 and read on R15 holding 12 → read returns 12. The next read returns 55. Assert `iRstN` mid-sequence → registers back to defaults immediately.

Source files
------------

// File: rtl/video_cga_crtc_regs_pkg.sv
// Shared CGA video definitions: CRTC register indices, reset values, store masks
// and cursor blink-mode encodings.
package video_pkg;

   localparam int NUM_REGS = 16;

   localparam logic [4:0] R_MAX_SCAN  = 5'd9;
   localparam logic [4:0] R_CUR_START = 5'd10;
   localparam logic [4:0] R_CUR_END   = 5'd11;
   localparam logic [4:0] R_START_HI  = 5'd12;
   localparam logic [4:0] R_START_LO  = 5'd13;
   localparam logic [4:0] R_CURSOR_HI = 5'd14;
   localparam logic [4:0] R_CURSOR_LO = 5'd15;
   localparam logic [4:0] R_LPEN_HI   = 5'd16;
   localparam logic [4:0] R_LPEN_LO   = 5'd17;

   // iAddr[11:3] for the 3D0-3D7 port window; iAddr[0] splits index from data.
   localparam logic [8:0] CRTC_PORT_HI = 9'h07A;

   typedef enum logic [1:0] {
      CUR_STEADY    = 2'b00,
      CUR_OFF       = 2'b01,
      CUR_BLINK_FC3 = 2'b10,
      CUR_BLINK_FC4 = 2'b11
   } cursor_mode_e;

   // Bits each register actually stores; everything else reads back as 0.
   function automatic logic [7:0] reg_mask(input logic [3:0] idx);
      case (idx)
         4'd4, 4'd6, 4'd7, 4'd10: reg_mask = 8'h7F;
         4'd5, 4'd9, 4'd11:       reg_mask = 8'h1F;
         4'd8:                    reg_mask = 8'h03;
         4'd12, 4'd14:            reg_mask = 8'h3F;
         default:                 reg_mask = 8'hFF;
      endcase
   endfunction

   // 80x25 text-mode defaults; R9-R11 come from the top-level parameters.
   function automatic logic [7:0] fixed_reset(input logic [3:0] idx);
      case (idx)
         4'd0:    fixed_reset = 8'h71;
         4'd1:    fixed_reset = 8'h50;
         4'd2:    fixed_reset = 8'h5A;
         4'd3:    fixed_reset = 8'h0A;
         4'd4:    fixed_reset = 8'h1F;
         4'd5:    fixed_reset = 8'h06;
         4'd6:    fixed_reset = 8'h19;
         4'd7:    fixed_reset = 8'h1C;
         4'd8:    fixed_reset = 8'h02;
         default: fixed_reset = 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/video_cga_crtc_regs_if.sv
// CPU IO bus as seen by the CRTC register file: address, strobes, write and read data.
interface video_cga_crtc_regs_if;
   logic [19:0] iAddr;
   logic [7:0]  iWrData;
   logic        iWrIo;
   logic        iRdIo;
   logic [7:0]  oRdData;
   logic        oSel;

   modport master (output iAddr, iWrData, iWrIo, iRdIo, input oRdData, oSel);
   modport slave  (input iAddr, iWrData, iWrIo, iRdIo, output oRdData, oSel);
endinterface

// File: rtl/video_cga_crtc_regs_blink_gen.sv
// Vsync synchronizer, rising-edge detector and 5-bit field counter driving the
// cursor and character blink phases.
module video_blink_gen (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       vs,
   output logic [4:0] fc
);

   logic vs_meta;
   logic vs_sync;
   logic vs_prev;

   // NOTE: non-blocking assignments keep the three flops a true shift chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_meta <= 1'b0;
         vs_sync <= 1'b0;
         vs_prev <= 1'b0;
         fc      <= 5'd0;
      end else begin
         vs_meta <= vs;
         vs_sync <= vs_meta;
         vs_prev <= vs_sync;
         if (vs_sync && !vs_prev)
            fc <= fc + 5'd1;
      end
   end

endmodule

// File: rtl/video_cga_crtc_regs.sv
// 6845-compatible CRTC register file for the CGA path: port decode, R0-R15 storage,
// readback, and the cursor/character blink outputs.
module video_cga_crtc_regs
   import video_pkg::*;
#(
   parameter logic [7:0] RESET_R9  = 8'h07,
   parameter logic [7:0] RESET_R10 = 8'h06,
   parameter logic [7:0] RESET_R11 = 8'h07
) (
   input  logic                        iClk,
   input  logic                        iRstN,
   video_cga_crtc_regs_if.slave        bus,
   input  logic                        iVgaVs,
   output logic [13:0]                 oStartAddr,
   output logic [13:0]                 oCursorAddr,
   output logic [4:0]                  oCursorStart,
   output logic [4:0]                  oCursorEnd,
   output logic [4:0]                  oMaxScan,
   output logic                        oCursorOn,
   output logic                        oCharBlink
);

   logic [4:0] index;
   logic [7:0] regs [NUM_REGS];
   logic [4:0] fc;
   logic       port_hit;
   logic       idx_wr;
   logic       data_wr;
   logic       data_rd;
   logic [7:0] rd_value;
   logic       unused_addr_bits;

   function automatic logic [7:0] reset_val(input logic [3:0] idx);
      case (idx)
         4'd9:    reset_val = RESET_R9  & reg_mask(idx);
         4'd10:   reset_val = RESET_R10 & reg_mask(idx);
         4'd11:   reset_val = RESET_R11 & reg_mask(idx);
         default: reset_val = fixed_reset(idx);
      endcase
   endfunction

   assign unused_addr_bits = &{1'b0, bus.iAddr[19:12], bus.iAddr[2:1]};

   assign port_hit = (bus.iAddr[11:3] == CRTC_PORT_HI);
   assign idx_wr   = port_hit && !bus.iAddr[0] && bus.iWrIo;
   assign data_wr  = port_hit &&  bus.iAddr[0] && bus.iWrIo;
   assign data_rd  = port_hit &&  bus.iAddr[0] && bus.iRdIo;

   // NOTE: the register file is small and its reset values are architectural, so
   // every entry is reset rather than treated as uninitialised memory.
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         index <= 5'd0;
         for (int i = 0; i < NUM_REGS; i++)
            regs[i] <= reset_val(4'(i));
      end else begin
         if (idx_wr)
            index <= bus.iWrData[4:0];
         if (data_wr && !index[4])
            regs[index[3:0]] <= bus.iWrData & reg_mask(index[3:0]);
      end
   end

   // Only the address registers read back; light pen and timing registers read 0.
   always_comb begin
      rd_value = 8'h00;
      case (index)
         R_START_HI, R_START_LO, R_CURSOR_HI, R_CURSOR_LO: rd_value = regs[index[3:0]];
         default:                                          rd_value = 8'h00;
      endcase
   end

   // Samples the pre-write contents, so a same-cycle write and read returns the old value.
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         bus.oSel    <= 1'b0;
         bus.oRdData <= 8'h00;
      end else begin
         bus.oSel    <= data_rd;
         bus.oRdData <= data_rd ? rd_value : 8'h00;
      end
   end

   video_blink_gen u_blink (
      .clk   (iClk),
      .rst_n (iRstN),
      .vs    (iVgaVs),
      .fc    (fc)
   );

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         oCursorOn <= 1'b1;
      end else begin
         case (cursor_mode_e'(regs[R_CUR_START[3:0]][6:5]))
            CUR_STEADY:    oCursorOn <= 1'b1;
            CUR_OFF:       oCursorOn <= 1'b0;
            CUR_BLINK_FC3: oCursorOn <= fc[3];
            CUR_BLINK_FC4: oCursorOn <= fc[4];
            default:       oCursorOn <= 1'b1;
         endcase
      end
   end

   assign oStartAddr   = {regs[R_START_HI[3:0]][5:0],  regs[R_START_LO[3:0]]};
   assign oCursorAddr  = {regs[R_CURSOR_HI[3:0]][5:0], regs[R_CURSOR_LO[3:0]]};
   assign oCursorStart = regs[R_CUR_START[3:0]][4:0];
   assign oCursorEnd   = regs[R_CUR_END[3:0]][4:0];
   assign oMaxScan     = regs[R_MAX_SCAN[3:0]][4:0];
   assign oCharBlink   = fc[4];

endmodule

// File: tb/tb_video_cga_crtc_regs.sv
// Directed bench for the CGA CRTC register file; a queue-based scoreboard checks
// every claimed read as the DUT presents it.
module tb_video_cga_crtc_regs;

   logic        clk;
   logic        rst_n;
   logic        vga_vs;
   logic [13:0] start_addr;
   logic [13:0] cursor_addr;
   logic [4:0]  cursor_start;
   logic [4:0]  cursor_end;
   logic [4:0]  max_scan;
   logic        cursor_on;
   logic        char_blink;

   int n_vec;
   int n_bad;
   logic [7:0] exp_q [$];

   video_cga_crtc_regs_if bus ();

   video_cga_crtc_regs dut (
      .iClk         (clk),
      .iRstN        (rst_n),
      .bus          (bus),
      .iVgaVs       (vga_vs),
      .oStartAddr   (start_addr),
      .oCursorAddr  (cursor_addr),
      .oCursorStart (cursor_start),
      .oCursorEnd   (cursor_end),
      .oMaxScan     (max_scan),
      .oCursorOn    (cursor_on),
      .oCharBlink   (char_blink)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Read-data monitor: pops one expectation per claimed read.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.oSel) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_bad++;
               $display("FAIL unexpected_claim: oSel=1 rd_data=%0h, expected no claim", bus.oRdData);
            end else begin
               check("rd_data", {24'd0, bus.oRdData}, {24'd0, exp_q.pop_front()});
            end
         end else begin
            check("idle_rd_data", {24'd0, bus.oRdData}, 32'd0);
         end
      end
   end

   task automatic io_wr(input logic [19:0] a, input logic [7:0] d);
      bus.iAddr   = a;
      bus.iWrData = d;
      bus.iWrIo   = 1'b1;
      @(posedge clk); #1;
      bus.iWrIo   = 1'b0;
   endtask

   task automatic io_rd(input logic [19:0] a, input logic [7:0] req, input bit claimed);
      bus.iAddr = a;
      bus.iRdIo = 1'b1;
      if (claimed) exp_q.push_back(req);
      @(posedge clk); #1;
      bus.iRdIo = 1'b0;
   endtask

   task automatic crtc_wr(input logic [7:0] idx, input logic [7:0] d);
      io_wr(20'h003D4, idx);
      io_wr(20'h003D5, d);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   // One full vsync pulse; fc and the cursor register have settled on return.
   task automatic vs_pulse();
      vga_vs = 1'b1;
      idle(2);
      vga_vs = 1'b0;
      idle(4);
   endtask

   task automatic check_defaults(input string tag);
      check({tag, "_start_addr"},   {18'd0, start_addr},   32'h0);
      check({tag, "_cursor_addr"},  {18'd0, cursor_addr},  32'h0);
      check({tag, "_cursor_start"}, {27'd0, cursor_start}, 32'h06);
      check({tag, "_cursor_end"},   {27'd0, cursor_end},   32'h07);
      check({tag, "_max_scan"},     {27'd0, max_scan},     32'h07);
      check({tag, "_cursor_on"},    {31'd0, cursor_on},    32'h1);
      check({tag, "_char_blink"},   {31'd0, char_blink},   32'h0);
      check({tag, "_sel"},          {31'd0, bus.oSel},     32'h0);
      check({tag, "_rd_data"},      {24'd0, bus.oRdData},  32'h0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      n_vec = 0;
      n_bad = 0;
      rst_n = 1'b0;
      vga_vs = 1'b0;
      bus.iAddr = 20'h0;
      bus.iWrData = 8'h0;
      bus.iWrIo = 1'b0;
      bus.iRdIo = 1'b0;
      idle(3);
      rst_n = 1'b1;
      idle(1);
      check_defaults("reset");

      // R14 readback after reset
      io_wr(20'h003D4, 8'h0E);
      io_rd(20'h003D5, 8'h00, 1'b1);

      // Start address, with masking of R12 and upper address bits ignored
      crtc_wr(8'h0C, 8'h3F);
      crtc_wr(8'h0D, 8'hA5);
      check("start_addr", {18'd0, start_addr}, 32'h3FA5);
      io_wr(20'hF53D4, 8'h0C);
      io_wr(20'hF53D5, 8'hFF);
      check("start_addr_masked", {18'd0, start_addr}, 32'h3FA5);
      io_rd(20'h003D7, 8'h3F, 1'b1);

      // Cursor address low byte and mirrored data port
      crtc_wr(8'h0F, 8'h12);
      check("cursor_addr_lo", {24'd0, cursor_addr[7:0]}, 32'h12);
      io_rd(20'h003D1, 8'h12, 1'b1);
      crtc_wr(8'h0E, 8'hFF);
      check("cursor_addr", {18'd0, cursor_addr}, 32'h3F12);
      io_rd(20'h003D3, 8'h3F, 1'b1);
      io_wr(20'h003D4, 8'h00);
      io_rd(20'h003D5, 8'h00, 1'b1);
      io_rd(20'h003D4, 8'h00, 1'b0);
      io_rd(20'h003D9, 8'h00, 1'b0);

      // Address outside the window changes nothing
      io_wr(20'h003D2, 8'h0E);
      io_wr(20'h003D9, 8'h00);
      check("ignored_port", {18'd0, cursor_addr}, 32'h3F12);

      // Light pen reads zero and ignores writes
      crtc_wr(8'h10, 8'hAA);
      io_rd(20'h003D5, 8'h00, 1'b1);

      // Width masking on shape registers
      crtc_wr(8'h09, 8'hFF);
      check("max_scan_masked", {27'd0, max_scan}, 32'h1F);
      crtc_wr(8'h0B, 8'hE3);
      check("cursor_end_masked", {27'd0, cursor_end}, 32'h03);

      // Cursor blink mode 10: follows fc[3]
      crtc_wr(8'h0A, 8'h46);
      check("cursor_start", {27'd0, cursor_start}, 32'h06);
      idle(1);
      check("cursor_mode10_fc0", {31'd0, cursor_on}, 32'h0);
      repeat (7) vs_pulse();
      check("cursor_fc7", {31'd0, cursor_on}, 32'h0);
      vga_vs = 1'b1;
      idle(2);
      vga_vs = 1'b0;
      idle(1);
      check("cursor_edge_plus3", {31'd0, cursor_on}, 32'h0);
      idle(1);
      check("cursor_edge_plus4", {31'd0, cursor_on}, 32'h1);
      idle(2);
      crtc_wr(8'h0A, 8'h26);
      idle(1);
      check("cursor_mode01", {31'd0, cursor_on}, 32'h0);
      crtc_wr(8'h0A, 8'h06);
      idle(1);
      check("cursor_mode00", {31'd0, cursor_on}, 32'h1);
      crtc_wr(8'h0A, 8'h66);
      idle(1);
      check("cursor_mode11_fc8", {31'd0, cursor_on}, 32'h0);

      // Simultaneous write and read of R15 returns the old value
      io_wr(20'h003D4, 8'h0F);
      bus.iAddr = 20'h003D5;
      bus.iWrData = 8'h55;
      bus.iWrIo = 1'b1;
      bus.iRdIo = 1'b1;
      exp_q.push_back(8'h12);
      @(posedge clk); #1;
      bus.iWrIo = 1'b0;
      bus.iRdIo = 1'b0;
      io_rd(20'h003D5, 8'h55, 1'b1);
      idle(1);

      // Reset with a read in flight: the claim is dropped immediately
      bus.iAddr = 20'h003D5;
      bus.iRdIo = 1'b1;
      @(posedge clk); #1;
      bus.iRdIo = 1'b0;
      rst_n = 1'b0;
      #1;
      check_defaults("midreset");
      idle(2);
      rst_n = 1'b1;
      idle(1);
      io_wr(20'h003D4, 8'h0F);
      io_rd(20'h003D5, 8'h00, 1'b1);

      // 32 fields: char blink follows fc[4], counter wraps back to 0
      crtc_wr(8'h0A, 8'h66);
      for (int k = 1; k <= 32; k++) begin
         vs_pulse();
         if (k == 15 || k == 16 || k == 31 || k == 32) begin
            check($sformatf("char_blink_%0d", k), {31'd0, char_blink}, {31'd0, ((k % 32) >= 16)});
            check($sformatf("cursor_fc4_%0d", k), {31'd0, cursor_on}, {31'd0, ((k % 32) >= 16)});
         end
      end

      idle(3);
      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
